sdram_init_sequencer: RTL and testbench
=======================================

Name: sdram_init_sequencer

Overview:
- Sequences SDRAM bring-up on the 142.857 MHz SDRAM clock produced by the SDRAM PLL.
- Qualifies the PLL lock signal, holds the SDRAM in INHIBIT with CKE low until the lock is stable, then issues the JEDEC power-up sequence: wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER.
- Asserts init_done so the SDRAM read/write controller can take over the command bus.
- Falls back to a full re-initialisation whenever the lock is lost.

Parameters:
- ADDR_W, 13, SDRAM address width.
- BA_W, 2, bank address width.
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before power-up starts.
- POWERUP_CYCLES, 28572, NOP cycles with CKE high before PRECHARGE (200 us at 142.857 MHz).
- T_RP, 3, cycles from PRECHARGE to the next command.
- T_RFC, 10, cycles from REFRESH to the next command.
- T_MRD, 2, cycles from LOAD MODE to init_done.
- REFRESH_COUNT, 8, number of AUTO REFRESH commands.
- MODE_REG, 13'h030, mode word: CAS latency 3, burst length 1, sequential.

Ports:
- clk  in  1  SDRAM clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock; asynchronous to clk
- sdram_cke  out  1  clock enable
- sdram_cs_n  out  1  chip select
- sdram_ras_n  out  1  row address strobe
- sdram_cas_n  out  1  column address strobe
- sdram_we_n  out  1  write enable
- sdram_ba  out  BA_W  bank address
- sdram_addr  out  ADDR_W  address
- init_done  out  1  high once initialisation is complete; level signal
- state_dbg  out  4  current state encoding, for LEDs/debug

Behaviour:
- Reset (rst_n low, asynchronous): state WAIT_LOCK; cke=0, cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0, init_done=0; all counters 0; lock synchroniser cleared.
- Lock synchronisation: pll_locked passes through a 2-flop synchroniser; lock_s denotes the synchronised value.
- All command outputs are registered. A command decided in cycle t appears on the pins in cycle t+1.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - INHIBIT 1111
  - NOP 0111
  - PRECHARGE 0010 (addr[10]=1, i.e. all banks)
  - REFRESH 0001
  - LOAD MODE 0000 (ba=0, addr=MODE_REG)
  - Outside those commands, addr=0 and ba=0.
- State machine:
  - WAIT_LOCK: outputs INHIBIT, cke=0. On lock_s=1, clear the counter and go to LOCK_STABLE.
  - LOCK_STABLE: outputs INHIBIT, cke=0; counter increments. If lock_s=0, return to WAIT_LOCK. When the counter reaches LOCK_STABLE_CYCLES-1, go to POWERUP.
  - POWERUP: cke=1, NOP for exactly POWERUP_CYCLES cycles, then go to PRECHARGE.
  - PRECHARGE: one cycle of PRECHARGE ALL, then WAIT_RP.
  - WAIT_RP: NOP for T_RP-1 cycles, then REFRESH.
  - REFRESH: one cycle of REFRESH; refresh counter increments; go to WAIT_RFC.
  - WAIT_RFC: NOP for T_RFC-1 cycles. Then go to REFRESH if fewer than REFRESH_COUNT refreshes have been issued, otherwise LOAD_MODE.
  - LOAD_MODE: one cycle of LOAD MODE, then WAIT_MRD.
  - WAIT_MRD: NOP for T_MRD-1 cycles, then DONE.
  - DONE: init_done=1 and cke=1. The block drives NOP; the downstream controller muxes the bus on init_done.
- Resulting spacing: consecutive commands are exactly T_RP, T_RFC or T_MRD cycles apart. init_done rises exactly T_MRD cycles after the LOAD MODE cycle.
- Lock loss: lock_s=0 in any state from POWERUP to DONE forces the next state to WAIT_LOCK. On the following output cycle: init_done=0, cke=0, INHIBIT, all counters cleared. Re-lock reruns the entire sequence.
- Reset mid-operation: rst_n low takes effect immediately and asynchronously; no partial sequence resumes.
- Counter width: the wait counter is wide enough for max(POWERUP_CYCLES, LOCK_STABLE_CYCLES). The refresh counter is 4 bits minimum.
- Parameter guards: elaboration asserts that T_RP, T_RFC and T_MRD are each >= 1 and that REFRESH_COUNT is >= 1.

Decomposition:
- Package sdram_pkg holds:
  - command encoding constants (CMD_INHIBIT, CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE);
  - the state enum (4 bits);
  - default timing constants and MODE_REG default.
  - The read/write controller shares this package.
- One sub-module, sdram_lock_sync: the 2-flop synchroniser on pll_locked, with async active-low reset.

Test Plan (bench overrides LOCK_STABLE_CYCLES=4, POWERUP_CYCLES=10; all other parameters at default):
- Reset check: hold rst_n=0 with pll_locked=1 -> cke=0, cs_n=1, init_done=0, state_dbg=WAIT_LOCK throughout.
- Full sequence: release reset, pll_locked=1 steady:
  - cke rises, then exactly 10 NOP cycles;
  - PRECHARGE with addr=13'h400;
  - first REFRESH exactly 3 cycles later, then 8 REFRESH commands spaced 10 cycles apart;
  - LOAD MODE with ba=0, addr=13'h030 exactly 10 cycles after the last REFRESH;
  - init_done rises exactly 2 cycles after LOAD MODE.
- Lock glitch: drop pll_locked for 2 cycles during LOCK_STABLE -> return to WAIT_LOCK; cke stays 0; a full 4-cycle stability window restarts after re-lock.
- Lock loss after DONE: pll_locked 1->0 -> within 3 clocks, init_done=0, cke=0, INHIBIT. Re-lock -> the complete sequence repeats with identical spacing.
- Async reset during the 4th REFRESH gap -> outputs go to reset values without a clock edge. After release, the sequence restarts from WAIT_LOCK and issues exactly 8 refreshes.
- Lock loss during POWERUP (cycle 5) -> no PRECHARGE is ever issued before the restart; the refresh counter reads 0 on the next REFRESH count.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init states, default timing.
// Imported by the init sequencer and the read/write controller.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK   = 4'd0,
        ST_LOCK_STABLE = 4'd1,
        ST_POWERUP     = 4'd2,
        ST_PRECHARGE   = 4'd3,
        ST_WAIT_RP     = 4'd4,
        ST_REFRESH     = 4'd5,
        ST_WAIT_RFC    = 4'd6,
        ST_LOAD_MODE   = 4'd7,
        ST_WAIT_MRD    = 4'd8,
        ST_DONE        = 4'd9
    } init_state_t;

    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_POWERUP_CYCLES     = 28572;
    localparam int DEF_T_RP               = 3;
    localparam int DEF_T_RFC              = 10;
    localparam int DEF_T_MRD              = 2;
    localparam int DEF_REFRESH_COUNT      = 8;
    localparam logic [12:0] DEF_MODE_REG  = 13'h030;

endpackage

// File: rtl/sdram_init_sequencer_lock_sync.sv
// Two-flop synchroniser bringing the PLL lock into the SDRAM clock domain.
// Cleared by reset so a fresh bring-up never trusts a stale lock.
module sdram_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Shift the asynchronous lock through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up sequencer: qualify PLL lock, then PRECHARGE ALL,
// N x AUTO REFRESH, LOAD MODE; restarts from scratch on lock loss.
module sdram_init_sequencer
    import sdram_pkg::*;
#(
    parameter int ADDR_W             = 13,
    parameter int BA_W               = 2,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int POWERUP_CYCLES     = DEF_POWERUP_CYCLES,
    parameter int T_RP               = DEF_T_RP,
    parameter int T_RFC              = DEF_T_RFC,
    parameter int T_MRD              = DEF_T_MRD,
    parameter int REFRESH_COUNT      = DEF_REFRESH_COUNT,
    parameter logic [ADDR_W-1:0] MODE_REG = ADDR_W'(DEF_MODE_REG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              init_done,
    output logic [3:0]        state_dbg
);

    localparam int CNT_MAX = (POWERUP_CYCLES > LOCK_STABLE_CYCLES) ?
                             POWERUP_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REF_NAT = $clog2(REFRESH_COUNT + 1);
    localparam int REF_W   = (REF_NAT > 4) ? REF_NAT : 4;

    if (T_RP < 1) begin : g_bad_trp
        $error("T_RP must be >= 1");
    end
    if (T_RFC < 1) begin : g_bad_trfc
        $error("T_RFC must be >= 1");
    end
    if (T_MRD < 1) begin : g_bad_tmrd
        $error("T_MRD must be >= 1");
    end
    if (REFRESH_COUNT < 1) begin : g_bad_rc
        $error("REFRESH_COUNT must be >= 1");
    end

    init_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic [3:0]        cmd_d;
    logic              cke_d, done_d, lock_s, lock_lost;
    logic [BA_W-1:0]   ba_d;
    logic [ADDR_W-1:0] addr_d;

    sdram_lock_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pll_locked),
        .sync_out (lock_s)
    );

    assign state_dbg = state_q;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
        end
    end

    // Next state and the command to present on the following cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        cmd_d     = CMD_NOP;
        cke_d     = 1'b1;
        ba_d      = '0;
        addr_d    = '0;
        done_d    = 1'b0;
        lock_lost = !lock_s && (state_q != ST_WAIT_LOCK) &&
                    (state_q != ST_LOCK_STABLE);
        unique case (state_q)
            ST_WAIT_LOCK: begin
                cmd_d = CMD_INHIBIT;
                cke_d = 1'b0;
                ref_d = '0;
                if (lock_s) begin
                    cnt_d   = '0;
                    state_d = ST_LOCK_STABLE;
                end
            end
            ST_LOCK_STABLE: begin
                cmd_d = CMD_INHIBIT;
                cke_d = 1'b0;
                ref_d = '0;
                if (!lock_s) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_POWERUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_POWERUP: begin
                if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_PRECHARGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRECHARGE: begin
                cmd_d      = CMD_PRECHARGE;
                addr_d[10] = 1'b1;
                cnt_d      = '0;
                state_d    = (T_RP > 1) ? ST_WAIT_RP : ST_REFRESH;
            end
            ST_WAIT_RP: begin
                if (cnt_q == CNT_W'(T_RP - 2)) begin
                    cnt_d   = '0;
                    state_d = ST_REFRESH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REFRESH: begin
                cmd_d = CMD_REFRESH;
                ref_d = ref_q + 1'b1;
                cnt_d = '0;
                if (T_RFC > 1)
                    state_d = ST_WAIT_RFC;
                else if (ref_d >= REF_W'(REFRESH_COUNT))
                    state_d = ST_LOAD_MODE;
                else
                    state_d = ST_REFRESH;
            end
            ST_WAIT_RFC: begin
                if (cnt_q == CNT_W'(T_RFC - 2)) begin
                    cnt_d   = '0;
                    state_d = (ref_q >= REF_W'(REFRESH_COUNT)) ?
                              ST_LOAD_MODE : ST_REFRESH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOAD_MODE: begin
                cmd_d   = CMD_LOAD_MODE;
                addr_d  = MODE_REG;
                cnt_d   = '0;
                state_d = (T_MRD > 1) ? ST_WAIT_MRD : ST_DONE;
            end
            ST_WAIT_MRD: begin
                if (cnt_q == CNT_W'(T_MRD - 2)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                cmd_d   = CMD_INHIBIT;
                cke_d   = 1'b0;
                cnt_d   = '0;
                ref_d   = '0;
                state_d = ST_WAIT_LOCK;
            end
        endcase
        // Lock loss drops the memory back to INHIBIT on the very next cycle
        if (lock_lost) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            ref_d   = '0;
            cmd_d   = CMD_INHIBIT;
            cke_d   = 1'b0;
            ba_d    = '0;
            addr_d  = '0;
            done_d  = 1'b0;
        end
    end

    // Registered command bus and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_cke  <= 1'b0;
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_INHIBIT;
            sdram_ba   <= '0;
            sdram_addr <= '0;
            init_done  <= 1'b0;
        end else begin
            sdram_cke  <= cke_d;
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_d;
            sdram_ba   <= ba_d;
            sdram_addr <= addr_d;
            init_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Bench for sdram_init_sequencer: timeline model of the bring-up
// sequence plus directed lock/reset scenarios.
module tb_sdram_init_sequencer;

    localparam int LS   = 4;
    localparam int PU   = 10;
    localparam int TRP  = 3;
    localparam int TRFC = 10;
    localparam int TMRD = 2;
    localparam int RC   = 8;
    localparam logic [20:0] RST_V = {1'b0, 4'b1111, 2'b00, 13'h0, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked = 1'b1;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic        init_done;
    logic [3:0]  state_dbg;

    int total = 0;
    int bad = 0;

    sdram_init_sequencer #(
        .LOCK_STABLE_CYCLES (LS),
        .POWERUP_CYCLES     (PU)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_ba    (sdram_ba),
        .sdram_addr  (sdram_addr),
        .init_done   (init_done),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // Expected pins given k = consecutive cycles the synchronised lock
    // has been high (k=0: low). Pins show the decision one cycle later.
    function automatic logic [20:0] decide(input int k);
        int j, pre, ref0, lm;
        if (k <= LS + 1) return RST_V;
        j    = k - (LS + 1);
        pre  = PU + 1;
        ref0 = pre + TRP;
        lm   = ref0 + RC * TRFC;
        if (j == pre) return {1'b1, 4'b0010, 2'b00, 13'h400, 1'b0};
        if (j >= ref0 && j < lm && ((j - ref0) % TRFC) == 0)
            return {1'b1, 4'b0001, 2'b00, 13'h0, 1'b0};
        if (j == lm) return {1'b1, 4'b0000, 2'b00, 13'h030, 1'b0};
        if (j >= lm + TMRD) return {1'b1, 4'b0111, 2'b00, 13'h0, 1'b1};
        return {1'b1, 4'b0111, 2'b00, 13'h0, 1'b0};
    endfunction

    logic [20:0] exp_v = RST_V;
    logic [20:0] act;
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    int run = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            run = 0;
            exp_v = RST_V;
        end else begin
            if (m_s2) run++;
            else run = 0;
            exp_v = decide(run);
            m_s2 = m_s1;
            m_s1 = pll_locked;
        end
    end

    int cyc = 0;
    int cke_c, pre_c, lm_c, done_c;
    int refs[$];
    logic [12:0] pre_addr, lm_addr;
    logic [1:0] lm_ba;
    logic prev_cke = 1'b0;

    function automatic logic [3:0] cmd();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    endfunction

    // Per-cycle compare against the model, plus event timestamps
    always @(negedge clk) begin
        act = {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
               sdram_ba, sdram_addr, init_done};
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL pins cyc=%0d got=%h want=%h", cyc, act, exp_v);
        end
        if (!rst_n) cyc = 0;
        else cyc++;
        if (sdram_cke && !prev_cke && cke_c < 0) cke_c = cyc;
        if (cmd() == 4'b0010 && pre_c < 0) begin
            pre_c = cyc;
            pre_addr = sdram_addr;
        end
        if (cmd() == 4'b0001) refs.push_back(cyc);
        if (cmd() == 4'b0000 && lm_c < 0) begin
            lm_c = cyc;
            lm_addr = sdram_addr;
            lm_ba = sdram_ba;
        end
        if (init_done && done_c < 0) done_c = cyc;
        prev_cke = sdram_cke;
    end

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, req);
        end
    endtask

    task automatic clear_marks();
        cke_c = -1;
        pre_c = -1;
        lm_c = -1;
        done_c = -1;
        refs.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (init_done !== 1'b1 && i < 400) begin
            @(negedge clk);
            #1;
            i++;
        end
        check(name, int'(init_done), 1);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_pu_gap"}, pre_c - cke_c, PU);
        check({tag, "_pre_addr"}, int'(pre_addr), 'h400);
        check({tag, "_ref_n"}, refs.size(), RC);
        if (refs.size() == RC) begin
            check({tag, "_rp_gap"}, refs[0] - pre_c, TRP);
            for (int i = 1; i < RC; i++)
                check({tag, "_rfc_gap"}, refs[i] - refs[i-1], TRFC);
            check({tag, "_lm_gap"}, lm_c - refs[RC-1], TRFC);
        end
        check({tag, "_lm_addr"}, int'(lm_addr), 'h030);
        check({tag, "_lm_ba"}, int'(lm_ba), 0);
        check({tag, "_mrd_gap"}, done_c - lm_c, TMRD);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        clear_marks();
    endtask

    initial begin
        int r0, i;
        clear_marks();
        // Reset held with lock present
        step(5);
        check("rst_cke", int'(sdram_cke), 0);
        check("rst_cs_n", int'(sdram_cs_n), 1);
        check("rst_done", int'(init_done), 0);
        check("rst_state", int'(state_dbg), 0);

        // Full sequence from reset release
        rst_n = 1'b1;
        clear_marks();
        wait_done("full_done");
        check("full_cke_at", cke_c, 8);
        check("full_done_at", done_c, 103);
        check_seq("full");

        // Lock loss after DONE, then re-lock
        step(3);
        pll_locked = 1'b0;
        step(3);
        check("loss_done", int'(init_done), 0);
        check("loss_cke", int'(sdram_cke), 0);
        check("loss_cmd", int'(cmd()), 'hF);
        step(5);
        pll_locked = 1'b1;
        clear_marks();
        r0 = cyc;
        wait_done("relock_done");
        check("relock_cke_lat", cke_c - r0, 8);
        check_seq("relock");

        // Lock glitch during the stability window
        do_reset();
        i = 0;
        while (state_dbg != 4'd1 && i < 20) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("glitch_in_ls", int'(state_dbg), 1);
        pll_locked = 1'b0;
        step(2);
        pll_locked = 1'b1;
        r0 = cyc;
        step(1);
        check("glitch_state", int'(state_dbg), 0);
        check("glitch_cke", int'(sdram_cke), 0);
        wait_done("glitch_done");
        check("glitch_cke_lat", cke_c - r0, 8);
        check_seq("glitch");

        // Async reset in the 4th refresh gap
        do_reset();
        i = 0;
        while (refs.size() < 4 && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("ar_ref4", refs.size(), 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_cke", int'(sdram_cke), 0);
        check("ar_cmd", int'(cmd()), 'hF);
        check("ar_done", int'(init_done), 0);
        check("ar_state", int'(state_dbg), 0);
        step(2);
        rst_n = 1'b1;
        clear_marks();
        wait_done("ar_done2");
        check_seq("ar");

        // Lock loss in the 5th powerup cycle
        do_reset();
        i = 0;
        while (cke_c < 0 && i < 50) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("pu_cke_up", int'(sdram_cke), 1);
        step(4);
        pll_locked = 1'b0;
        step(12);
        check("pu_no_pre", pre_c, -1);
        check("pu_cke_low", int'(sdram_cke), 0);
        pll_locked = 1'b1;
        clear_marks();
        wait_done("pu_done");
        check_seq("pu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
